pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement add/subtract unit; the sequential successor to the gate-level half/full adders. Operands are split into STAGES equal slices. Each pipeline stage ripples one slice through a chain of full-adder cells and registers the carry forward. Valid/ready handshakes on input and output allow use in streaming datapaths with backpressure.

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_slice.sv | 31 +++
 rtl/pipelined_adder.sv | 134 +++++++++++++
 tb/tb_pipelined_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the pipelined add/subtract unit.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int ADD_WIDTH  = 16;
  localparam int ADD_STAGES = 4;

  // SUB is a + ~b + 1, so the external carry-in only matters for ADD.
  function automatic logic carryIn(input op_e opSel, input logic cinBit);
    return (opSel == OP_SUB) ? 1'b1 : cinBit;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry
// into the most significant cell so the caller can derive signed overflow.
module adder_slice
  import adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = c_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o    = carry[CHUNK];
  assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract: one CHUNK-bit slice per stage, with
// valid/ready handshakes and bubble-collapsing backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADD_WIDTH,
  parameter int STAGES = ADD_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / ((STAGES > 0) ? STAGES : 1);

  if (STAGES < 1 || STAGES > WIDTH) begin : g_badStages
    $error("pipelined_adder: STAGES must lie in 1..WIDTH");
  end
  if (WIDTH % STAGES != 0) begin : g_badSplit
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic [STAGES-1:0] validQ;
  op_e               opQ    [STAGES];
  logic              carryQ [STAGES];
  logic              ovfQ   [STAGES];
  logic [WIDTH-1:0]  aQ     [STAGES];
  logic [WIDTH-1:0]  bQ     [STAGES];
  logic [WIDTH-1:0]  sumQ   [STAGES];

  logic [STAGES-1:0] validD;
  op_e               opD      [STAGES];
  logic              carryInD [STAGES];
  logic [WIDTH-1:0]  aD       [STAGES];
  logic [WIDTH-1:0]  bD       [STAGES];
  logic [WIDTH-1:0]  sumInD   [STAGES];
  logic [WIDTH-1:0]  sumD     [STAGES];
  logic              carryD   [STAGES];
  logic              ovfD     [STAGES];

  logic [STAGES-1:0] load;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

    logic [CHUNK-1:0] sliceSum;
    logic             sliceCout;
    logic             sliceCmsb;

    // Stage 0 adds straight from the input port; later stages from the previous register.
    if (k == 0) begin : g_src
      assign validD[k]   = in_valid;
      assign opD[k]      = op_e'(op);
      assign aD[k]       = a;
      assign bD[k]       = b;
      assign carryInD[k] = carryIn(op_e'(op), cin);
      assign sumInD[k]   = '0;
    end else begin : g_src
      assign validD[k]   = validQ[k-1];
      assign opD[k]      = opQ[k-1];
      assign aD[k]       = aQ[k-1];
      assign bD[k]       = bQ[k-1];
      assign carryInD[k] = carryQ[k-1];
      assign sumInD[k]   = sumQ[k-1];
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a_i    (aD[k][k*CHUNK +: CHUNK]),
      .b_i    (bD[k][k*CHUNK +: CHUNK] ^ {CHUNK{opD[k] == OP_SUB}}),
      .c_i    (carryInD[k]),
      .sum_o  (sliceSum),
      .c_o    (sliceCout),
      .cmsb_o (sliceCmsb)
    );

    assign sumD[k]   = (sumInD[k] & ~SLICE_MASK) | (WIDTH'(sliceSum) << (k * CHUNK));
    assign carryD[k] = sliceCout;
    assign ovfD[k]   = sliceCout ^ sliceCmsb;
  end

  // A stage may load whenever some stage at or after it is empty, or the consumer drains.
  always_comb begin
    load = '0;
    for (int k = 0; k < STAGES; k++) begin
      load[k] = out_ready || (((~validQ) >> k) != '0);
    end
  end

  assign in_ready = rst_n && load[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      validQ <= '0;
      for (int k = 0; k < STAGES; k++) begin
        opQ[k]    <= OP_ADD;
        carryQ[k] <= 1'b0;
        ovfQ[k]   <= 1'b0;
        aQ[k]     <= '0;
        bQ[k]     <= '0;
        sumQ[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          validQ[k] <= validD[k];
          if (validD[k]) begin
            opQ[k]    <= opD[k];
            carryQ[k] <= carryD[k];
            ovfQ[k]   <= ovfD[k];
            aQ[k]     <= aD[k];
            bQ[k]     <= bD[k];
            sumQ[k]   <= sumD[k];
          end
        end
      end
    end
  end

  assign out_valid = validQ[STAGES-1];
  assign sum       = sumQ[STAGES-1];
  assign cout      = carryQ[STAGES-1];
  assign ovf       = ovfQ[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases and random
// streams checked every cycle against an arithmetic reference model.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           entry;
  } exp_t;

  exp_t expQ[$];
  int   cyc         = 0;
  int   testsRun    = 0;
  int   testsFailed = 0;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic ov, input int entry);
    exp_t        e;
    int          sa, sb, sr;
    int unsigned ua, ub, ur;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = 32'(av);
    ub = 32'(bv);
    if (ov) begin
      ur  = ua - ub;
      e.c = (ua >= ub);
      sr  = sa - sb;
    end else begin
      ur  = ua + ub + 32'(cv);
      e.c = ur[W];
      sr  = sa + sb + int'(cv);
    end
    e.s     = ur[W-1:0];
    e.o     = (sr > 32767) || (sr < -32768);
    e.entry = entry;
    return e;
  endfunction

  // The oldest in-flight result never waits behind another, so it shows up exactly S cycles after entry.
  function automatic bit expValidNow();
    return (expQ.size() > 0) && (cyc - expQ[0].entry >= S);
  endfunction

  task automatic checkOutput();
    logic expReady;
    logic expValid;
    expReady = rst_n && !(expQ.size() == S && !out_ready);
    expValid = expValidNow();
    testsRun++;
    assert (in_ready === expReady) else begin
      testsFailed++;
      $error("[TB] FAIL in_ready cycle %0d: got %b expected %b", cyc, in_ready, expReady);
    end
    testsRun++;
    assert (out_valid === expValid) else begin
      testsFailed++;
      $error("[TB] FAIL out_valid cycle %0d: got %b expected %b", cyc, out_valid, expValid);
    end
    if (expValid) begin
      testsRun++;
      assert (sum === expQ[0].s) else begin
        testsFailed++;
        $error("[TB] FAIL sum cycle %0d: got %h expected %h", cyc, sum, expQ[0].s);
      end
      testsRun++;
      assert (cout === expQ[0].c) else begin
        testsFailed++;
        $error("[TB] FAIL cout cycle %0d: got %b expected %b", cyc, cout, expQ[0].c);
      end
      testsRun++;
      assert (ovf === expQ[0].o) else begin
        testsFailed++;
        $error("[TB] FAIL ovf cycle %0d: got %b expected %b", cyc, ovf, expQ[0].o);
      end
    end
  endtask

  // One clock cycle: inputs are already driven; check, update the model, then advance.
  task automatic tick(output bit took);
    bit popNow;
    #1;
    checkOutput();
    popNow = rst_n && expValidNow() && out_ready;
    took   = rst_n && in_valid && in_ready;
    if (popNow) void'(expQ.pop_front());
    if (took) expQ.push_back(model(a, b, cin, op, cyc));
    @(posedge clk);
    cyc++;
    if (!rst_n) expQ.delete();
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic ov);
    bit took;
    took = 1'b0;
    a = av; b = bv; cin = cv; op = ov;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !took; n++) tick(took);
    in_valid = 1'b0;
    if (!took) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL accept-timeout: got no transfer, expected one within 64 cycles");
    end
  endtask

  task automatic drainPipe();
    bit took;
    int n;
    n = 0;
    in_valid = 1'b0;
    while (expQ.size() > 0 && n < 64) begin
      tick(took);
      n++;
    end
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL drain-timeout: got %0d results pending, expected 0", expQ.size());
    end
  endtask

  task automatic runStream(input int count, input int stallFrom, input int stallTo);
    bit took;
    bit need;
    int sent;
    int i;
    sent = 0; i = 0; need = 1'b1;
    while ((sent < count || expQ.size() > 0) && i < 300) begin
      out_ready = !(i >= stallFrom && i <= stallTo);
      if (sent < count) begin
        if (need) begin
          a    = W'($urandom);
          b    = W'($urandom);
          cin  = 1'($urandom_range(0, 1));
          op   = 1'($urandom_range(0, 1));
          need = 1'b0;
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick(took);
      if (took) begin
        sent++;
        need = 1'b1;
      end
      i++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sent < count || expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL stream-timeout: got %0d sent / %0d pending, expected %0d sent / 0 pending",
             sent, expQ.size(), count);
    end
  endtask

  task automatic checkCleared(input string tag);
    testsRun++;
    assert (out_valid === 1'b0 && sum === '0 && cout === 1'b0 && ovf === 1'b0) else begin
      testsFailed++;
      $error("[TB] FAIL %s: got valid=%b sum=%h cout=%b ovf=%b expected all zero",
             tag, out_valid, sum, cout, ovf);
    end
  endtask

  initial begin
    bit took;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    assert (in_ready === 1'b0) else begin
      testsFailed++;
      $error("[TB] FAIL in_ready-in-reset: got %b expected 0", in_ready);
    end
    checkCleared("reset-state");
    rst_n = 1'b1;
    tick(took);

    $display("[TB] directed add / subtract corners");
    applyStimulus(16'h1234, 16'h4321, 1'b0, OP_ADD);  drainPipe();
    applyStimulus(16'h1234, 16'h4321, 1'b1, OP_ADD);  drainPipe();
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, OP_ADD);  drainPipe();
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, OP_ADD);  drainPipe();
    applyStimulus(16'h0005, 16'h0007, 1'b1, OP_SUB);  drainPipe();
    applyStimulus(16'h8000, 16'h0001, 1'b0, OP_SUB);  drainPipe();

    $display("[TB] 10 random beats with output stalled in cycles 3-9");
    runStream(10, 3, 9);

    $display("[TB] 20 random beats at full throughput");
    runStream(20, -1, -2);

    $display("[TB] reset with 3 beats in flight");
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++)
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    tick(took);
    checkCleared("after-mid-reset");
    rst_n = 1'b1;
    repeat (8) tick(took);

    $display("[TB] random beats after reset");
    runStream(12, 2, 5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
